// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths and starvation-FSM state encoding for the writeback port arbiter.
// No logic: constants and types only.
// Imported by wb_port_arbiter and wb_result_fifo.
package wb_port_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FORCE = 2'd2
  } starve_state_e;

endpackage

// File: rtl/wb_result_fifo.sv
// Circular buffer holding long-latency results until the RF write port is free.
// Latency: an entry pushed on an edge is visible at the head from the next cycle.
// Backpressure: the caller must not push when full_o or pop when empty_o.
module wb_result_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic [XLEN-1:0]       data_i,
  output logic [REG_ADDR_W-1:0] head_rd_o,
  output logic [XLEN-1:0]       head_data_o,
  output logic [CNT_W-1:0]      count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  logic [REG_ADDR_W-1:0] rd_mem_q   [DEPTH];
  logic [XLEN-1:0]       data_mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q,  count_d;

  // Pointer and occupancy next-state; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push_i) begin
      rd_mem_q[wr_ptr_q]   <= rd_i;
      data_mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign head_rd_o   = rd_mem_q[rd_ptr_q];
  assign head_data_o = data_mem_q[rd_ptr_q];
  assign count_o     = count_q;
  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign empty_o     = (count_q == '0);

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single RF write port between pipeline writeback (priority) and queued mul/div results.
// Latency: pipe writes pass through combinationally; queued results reach the RF >= 1 cycle after accept.
// Backpressure: lu_ready_o drops while the queue is full; stall_pipe_o requests a bubble on starvation.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_wr_en_wb_i,
  input  logic [REG_ADDR_W-1:0] pipe_rd_wb_i,
  input  logic [XLEN-1:0]       pipe_data_wb_i,
  input  logic                  issue_valid_i,
  input  logic [REG_ADDR_W-1:0] issue_rd_i,
  input  logic                  lu_valid_i,
  input  logic [REG_ADDR_W-1:0] lu_rd_i,
  input  logic [XLEN-1:0]       lu_data_i,
  output logic                  lu_ready_o,
  output logic                  rf_we_o,
  output logic [REG_ADDR_W-1:0] rf_waddr_o,
  output logic [XLEN-1:0]       rf_wdata_o,
  output logic [31:0]           busy_rd_o,
  output logic                  stall_pipe_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  logic                  pw;
  logic                  fifo_push, fifo_pop;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [XLEN-1:0]       head_data;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_full, fifo_empty;
  logic                  blocked, drains;

  starve_state_e         state_q, state_d;
  logic [SC_W-1:0]       starve_cnt_q, starve_cnt_d;
  logic                  stall_q, stall_d;
  logic [31:0]           busy_q, busy_d;

  // A write to x0 is architecturally void, so it never claims the port.
  assign pw         = pipe_wr_en_wb_i && (pipe_rd_wb_i != '0);
  // Readiness looks at occupancy only: a full queue draining this cycle still refuses.
  assign lu_ready_o = !rst && !fifo_full;
  assign fifo_push  = lu_valid_i && lu_ready_o;
  assign fifo_pop   = !pw && !fifo_empty;
  assign blocked    = pw && !fifo_empty;
  // Queue will hold nothing after this edge.
  assign drains     = fifo_pop && !fifo_push && (fifo_count == CNT_W'(1));

  wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .pop_i       (fifo_pop),
    .rd_i        (lu_rd_i),
    .data_i      (lu_data_i),
    .head_rd_o   (head_rd),
    .head_data_o (head_data),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Port select: pipe first, then the queue head; a popped x0 head is dropped without a write.
  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = pipe_rd_wb_i;
    rf_wdata_o = pipe_data_wb_i;
    if (pw) begin
      rf_we_o = 1'b1;
    end else if (!fifo_empty) begin
      rf_we_o    = (head_rd != '0);
      rf_waddr_o = head_rd;
      rf_wdata_o = head_data;
    end
    if (rst) rf_we_o = 1'b0;
  end

  // Scoreboard: clear on pop, then set on issue so a same-rd collision leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    if (fifo_pop) busy_d[head_rd] = 1'b0;
    if (issue_valid_i && (issue_rd_i != '0)) busy_d[issue_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Starvation FSM: count consecutive blocked cycles, request a bubble at the limit.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    stall_d      = stall_q;
    case (state_q)
      ST_IDLE: begin
        if (fifo_push) begin
          state_d      = ST_WAIT;
          starve_cnt_d = '0;
        end
      end
      ST_WAIT: begin
        if (fifo_pop) begin
          starve_cnt_d = '0;
          if (drains) state_d = ST_IDLE;
        end else if (blocked) begin
          if (starve_cnt_q == SC_W'(STARVE_LIMIT - 1)) begin
            starve_cnt_d = SC_W'(STARVE_LIMIT);
            state_d      = ST_FORCE;
            stall_d      = 1'b1;
          end else begin
            starve_cnt_d = starve_cnt_q + SC_W'(1);
          end
        end
      end
      ST_FORCE: begin
        if (fifo_pop) begin
          stall_d      = 1'b0;
          starve_cnt_d = '0;
          state_d      = drains ? ST_IDLE : ST_WAIT;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        starve_cnt_d = '0;
        stall_d      = 1'b0;
      end
    endcase
  end

  // State, counter, stall request and scoreboard registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      starve_cnt_q <= '0;
      stall_q      <= 1'b0;
      busy_q       <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      stall_q      <= stall_d;
      busy_q       <= busy_d;
    end
  end

  assign busy_rd_o    = busy_q;
  assign stall_pipe_o = stall_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench: directed vector table, hand sequences for multi-cycle corners,
// then constrained-random traffic against a queue-based reference model.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_wb_port_arbiter;

  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;

  logic        clk, rst;
  logic        pipe_wr_en_wb_i;
  logic [4:0]  pipe_rd_wb_i;
  logic [31:0] pipe_data_wb_i;
  logic        issue_valid_i;
  logic [4:0]  issue_rd_i;
  logic        lu_valid_i;
  logic [4:0]  lu_rd_i;
  logic [31:0] lu_data_i;
  logic        lu_ready_o;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic [31:0] busy_rd_o;
  logic        stall_pipe_o;

  int checks = 0;
  int errors = 0;

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk             (clk),
    .rst             (rst),
    .pipe_wr_en_wb_i (pipe_wr_en_wb_i),
    .pipe_rd_wb_i    (pipe_rd_wb_i),
    .pipe_data_wb_i  (pipe_data_wb_i),
    .issue_valid_i   (issue_valid_i),
    .issue_rd_i      (issue_rd_i),
    .lu_valid_i      (lu_valid_i),
    .lu_rd_i         (lu_rd_i),
    .lu_data_i       (lu_data_i),
    .lu_ready_o      (lu_ready_o),
    .rf_we_o         (rf_we_o),
    .rf_waddr_o      (rf_waddr_o),
    .rf_wdata_o      (rf_wdata_o),
    .busy_rd_o       (busy_rd_o),
    .stall_pipe_o    (stall_pipe_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream guarantees; an issue may hit a busy rd only while that rd's queued result is being written.
  always @(negedge clk) begin
    if (!rst) begin
      assert (!(issue_valid_i && issue_rd_i != 5'd0 && busy_rd_o[issue_rd_i]) ||
              (rf_we_o && !(pipe_wr_en_wb_i && pipe_rd_wb_i != 5'd0) && rf_waddr_o == issue_rd_i))
        else $error("upstream guarantee violated: issue to busy rd %0d", issue_rd_i);
      assert (!(pipe_wr_en_wb_i && pipe_rd_wb_i != 5'd0 && busy_rd_o[pipe_rd_wb_i]))
        else $error("upstream guarantee violated: pipe write to busy rd %0d", pipe_rd_wb_i);
      assert (!(lu_valid_i && lu_rd_i != 5'd0 && !busy_rd_o[lu_rd_i]))
        else $error("upstream guarantee violated: result for unissued rd %0d", lu_rd_i);
    end
  end

  typedef struct {
    logic        pwe;
    logic [4:0]  prd;
    logic [31:0] pdat;
    logic        iv;
    logic [4:0]  ird;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_rdy;
    logic        e_stall;
    logic [31:0] e_busy;
  } vec_t;

  function automatic vec_t v(input logic pwe, input logic [4:0] prd, input logic [31:0] pdat,
                             input logic iv, input logic [4:0] ird,
                             input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                             input logic e_we, input logic [4:0] e_addr, input logic [31:0] e_data,
                             input logic e_rdy, input logic e_stall, input logic [31:0] e_busy);
    vec_t r;
    r.pwe = pwe; r.prd = prd; r.pdat = pdat; r.iv = iv; r.ird = ird;
    r.lv = lv; r.lrd = lrd; r.ldat = ldat; r.e_we = e_we; r.e_addr = e_addr;
    r.e_data = e_data; r.e_rdy = e_rdy; r.e_stall = e_stall; r.e_busy = e_busy;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pwe, input logic [4:0] prd, input logic [31:0] pdat,
                       input logic iv, input logic [4:0] ird,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
    pipe_wr_en_wb_i = pwe; pipe_rd_wb_i = prd; pipe_data_wb_i = pdat;
    issue_valid_i = iv; issue_rd_i = ird;
    lu_valid_i = lv; lu_rd_i = lrd; lu_data_i = ldat;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model state
  typedef struct packed { logic [4:0] rd; logic [31:0] data; } ent_t;
  ent_t        mq[$];
  logic [31:0] mbusy;
  logic [4:0]  pend[$];
  bit          hold_v;
  logic [4:0]  hold_rd;
  logic [31:0] hold_dat;
  int          run;
  bit          mstall;

  vec_t tbl[19];

  initial begin
    logic        r_pwe, r_iv, m_pw, m_pop, m_push, e_we;
    logic [4:0]  r_prd, r_ird, e_addr, pop_rd;
    logic [31:0] r_pdat, e_data;
    int          pct, idx;

    // Directed table: lu write-through, starvation bubble, x0 pipe write, x0 result drop.
    tbl[0]  = v(0, 0, 0,            1, 5, 0, 0, 0,            0, 0, 0,            1, 0, 32'h0);
    tbl[1]  = v(0, 0, 0,            0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0,            1, 0, 32'h20);
    tbl[2]  = v(0, 0, 0,            0, 0, 0, 0, 0,            1, 5, 32'hDEADBEEF, 1, 0, 32'h20);
    tbl[3]  = v(0, 0, 0,            0, 0, 0, 0, 0,            0, 0, 0,            1, 0, 32'h0);
    tbl[4]  = v(1, 3, 32'h30000004, 1, 7, 0, 0, 0,            1, 3, 32'h30000004, 1, 0, 32'h0);
    tbl[5]  = v(1, 3, 32'h30000005, 0, 0, 1, 7, 32'h77,       1, 3, 32'h30000005, 1, 0, 32'h80);
    tbl[6]  = v(1, 3, 32'h30000006, 0, 0, 0, 0, 0,            1, 3, 32'h30000006, 1, 0, 32'h80);
    tbl[7]  = v(1, 3, 32'h30000007, 0, 0, 0, 0, 0,            1, 3, 32'h30000007, 1, 0, 32'h80);
    tbl[8]  = v(1, 3, 32'h30000008, 0, 0, 0, 0, 0,            1, 3, 32'h30000008, 1, 0, 32'h80);
    tbl[9]  = v(1, 3, 32'h30000009, 0, 0, 0, 0, 0,            1, 3, 32'h30000009, 1, 0, 32'h80);
    tbl[10] = v(1, 3, 32'h3000000A, 0, 0, 0, 0, 0,            1, 3, 32'h3000000A, 1, 1, 32'h80);
    tbl[11] = v(0, 0, 0,            0, 0, 0, 0, 0,            1, 7, 32'h77,       1, 1, 32'h80);
    tbl[12] = v(0, 0, 0,            0, 0, 0, 0, 0,            0, 0, 0,            1, 0, 32'h0);
    tbl[13] = v(0, 0, 0,            1, 4, 0, 0, 0,            0, 0, 0,            1, 0, 32'h0);
    tbl[14] = v(0, 0, 0,            0, 0, 1, 4, 32'h4444,     0, 0, 0,            1, 0, 32'h10);
    tbl[15] = v(1, 0, 32'hBAD,      0, 0, 0, 0, 0,            1, 4, 32'h4444,     1, 0, 32'h10);
    tbl[16] = v(1, 0, 32'hBAD,      0, 0, 1, 0, 32'h5555,     0, 0, 0,            1, 0, 32'h0);
    tbl[17] = v(0, 0, 0,            0, 0, 0, 0, 0,            0, 0, 0,            1, 0, 32'h0);
    tbl[18] = v(0, 0, 0,            0, 0, 0, 0, 0,            0, 0, 0,            1, 0, 32'h0);

    // Reset: pipe tries to write, but the port and readiness are forced low.
    rst = 1'b1;
    pipe_wr_en_wb_i = 1'b1; pipe_rd_wb_i = 5'd3; pipe_data_wb_i = 32'h1;
    issue_valid_i = 1'b0; issue_rd_i = '0; lu_valid_i = 1'b0; lu_rd_i = '0; lu_data_i = '0;
    #2;
    chk("reset rf_we", 32'(rf_we_o), 32'd0);
    chk("reset lu_ready", 32'(lu_ready_o), 32'd0);
    chk("reset busy", busy_rd_o, 32'h0);
    chk("reset stall", 32'(stall_pipe_o), 32'd0);
    tick();
    tick();
    pipe_wr_en_wb_i = 1'b0;
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].pwe, tbl[i].prd, tbl[i].pdat, tbl[i].iv, tbl[i].ird,
            tbl[i].lv, tbl[i].lrd, tbl[i].ldat);
      chk($sformatf("vec%0d rf_we", i), 32'(rf_we_o), 32'(tbl[i].e_we));
      if (tbl[i].e_we) begin
        chk($sformatf("vec%0d waddr", i), 32'(rf_waddr_o), 32'(tbl[i].e_addr));
        chk($sformatf("vec%0d wdata", i), rf_wdata_o, tbl[i].e_data);
      end
      chk($sformatf("vec%0d lu_ready", i), 32'(lu_ready_o), 32'(tbl[i].e_rdy));
      chk($sformatf("vec%0d stall", i), 32'(stall_pipe_o), 32'(tbl[i].e_stall));
      chk($sformatf("vec%0d busy", i), busy_rd_o, tbl[i].e_busy);
      tick();
    end

    // Full queue: third result held off, still refused in the draining cycle, accepted after.
    drive(0, 0, 0, 1, 10, 0, 0, 0); tick();
    drive(0, 0, 0, 1, 11, 0, 0, 0); tick();
    drive(1, 3, 32'h31, 1, 12, 1, 10, 32'hA0);
    chk("fill1 lu_ready", 32'(lu_ready_o), 32'd1); tick();
    drive(1, 3, 32'h32, 0, 0, 1, 11, 32'hB0);
    chk("fill2 lu_ready", 32'(lu_ready_o), 32'd1); tick();
    drive(1, 3, 32'h33, 0, 0, 1, 12, 32'hC0);
    chk("full lu_ready", 32'(lu_ready_o), 32'd0);
    chk("full busy", busy_rd_o, 32'h1C00);
    chk("full waddr", 32'(rf_waddr_o), 32'd3); tick();
    drive(0, 0, 0, 0, 0, 1, 12, 32'hC0);
    chk("drain-full lu_ready", 32'(lu_ready_o), 32'd0);
    chk("drain-full waddr", 32'(rf_waddr_o), 32'd10);
    chk("drain-full wdata", rf_wdata_o, 32'hA0); tick();
    drive(0, 0, 0, 0, 0, 1, 12, 32'hC0);
    chk("refill lu_ready", 32'(lu_ready_o), 32'd1);
    chk("refill waddr", 32'(rf_waddr_o), 32'd11);
    chk("refill wdata", rf_wdata_o, 32'hB0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("late we", 32'(rf_we_o), 32'd1);
    chk("late waddr", 32'(rf_waddr_o), 32'd12);
    chk("late wdata", rf_wdata_o, 32'hC0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("empty we", 32'(rf_we_o), 32'd0);
    chk("empty busy", busy_rd_o, 32'h0); tick();

    // Re-issue to rd 9 in the cycle its queued result pops: set wins.
    drive(0, 0, 0, 1, 9, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 1, 9, 32'h99);
    chk("rd9 push we", 32'(rf_we_o), 32'd0); tick();
    drive(0, 0, 0, 1, 9, 0, 0, 0);
    chk("rd9 pop we", 32'(rf_we_o), 32'd1);
    chk("rd9 pop waddr", 32'(rf_waddr_o), 32'd9); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rd9 set wins busy", busy_rd_o, 32'h200); tick();

    // Reset with two queued entries and busy = {5, 9}.
    drive(0, 0, 0, 1, 5, 0, 0, 0); tick();
    drive(1, 3, 32'h41, 0, 0, 1, 5, 32'h55);
    chk("q1 lu_ready", 32'(lu_ready_o), 32'd1); tick();
    drive(1, 3, 32'h42, 0, 0, 1, 9, 32'h99); tick();
    drive(1, 3, 32'h43, 0, 0, 0, 0, 0);
    chk("q2 busy", busy_rd_o, 32'h220);
    chk("q2 lu_ready", 32'(lu_ready_o), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("mid-reset busy", busy_rd_o, 32'h0);
    chk("mid-reset lu_ready", 32'(lu_ready_o), 32'd0);
    chk("mid-reset rf_we", 32'(rf_we_o), 32'd0);
    chk("mid-reset stall", 32'(stall_pipe_o), 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset lu_ready", 32'(lu_ready_o), 32'd1);
    chk("post-reset rf_we", 32'(rf_we_o), 32'd0);
    chk("post-reset busy", busy_rd_o, 32'h0);
    tick();
    @(negedge clk);
    chk("post-reset no stale we", 32'(rf_we_o), 32'd0);
    tick();

    // Random traffic against the reference model (DUT state is clean after the reset above).
    mq.delete(); pend.delete();
    mbusy = '0; hold_v = 0; hold_rd = '0; hold_dat = '0; run = 0; mstall = 0;
    for (int c = 0; c < 4000; c++) begin
      pct    = ((c / 400) % 2 == 0) ? 85 : 35;
      r_pwe  = ($urandom_range(99) < pct);
      r_prd  = 5'($urandom_range(31));
      if (r_prd != 5'd0 && mbusy[r_prd]) r_prd = 5'd0;
      r_pdat = $urandom;
      r_iv   = ($urandom_range(99) < 30);
      r_ird  = 5'($urandom_range(31));
      if (r_ird != 5'd0 && mbusy[r_ird]) r_iv = 1'b0;
      if (!hold_v && pend.size() > 0 && $urandom_range(99) < 50) begin
        idx      = int'($urandom_range(pend.size() - 1));
        hold_rd  = pend[idx];
        pend.delete(idx);
        hold_dat = $urandom;
        hold_v   = 1;
      end
      drive(r_pwe, r_prd, r_pdat, r_iv, r_ird, hold_v, hold_rd, hold_dat);

      // Expected outputs from the arbitration rules.
      m_pw   = r_pwe && r_prd != 5'd0;
      m_pop  = !m_pw && mq.size() > 0;
      m_push = hold_v && mq.size() < DEPTH;
      pop_rd = (mq.size() > 0) ? mq[0].rd : 5'd0;
      e_we   = m_pw || (m_pop && pop_rd != 5'd0);
      e_addr = m_pw ? r_prd : pop_rd;
      e_data = m_pw ? r_pdat : ((mq.size() > 0) ? mq[0].data : 32'h0);
      chk($sformatf("rnd%0d rf_we", c), 32'(rf_we_o), 32'(e_we));
      if (e_we) begin
        chk($sformatf("rnd%0d waddr", c), 32'(rf_waddr_o), 32'(e_addr));
        chk($sformatf("rnd%0d wdata", c), rf_wdata_o, e_data);
      end
      chk($sformatf("rnd%0d lu_ready", c), 32'(lu_ready_o), 32'(mq.size() < DEPTH));
      chk($sformatf("rnd%0d stall", c), 32'(stall_pipe_o), 32'(mstall));
      chk($sformatf("rnd%0d busy", c), busy_rd_o, mbusy);

      // Advance the model across the edge.
      if (m_pop) begin
        run = 0; mstall = 0;
      end else if (m_pw && mq.size() > 0) begin
        run++;
        if (run == STARVE_LIMIT) mstall = 1;
      end
      if (m_pop) begin
        mbusy[pop_rd] = 1'b0;
        void'(mq.pop_front());
      end
      if (r_iv) begin
        if (r_ird != 5'd0) mbusy[r_ird] = 1'b1;
        pend.push_back(r_ird);
      end
      mbusy[0] = 1'b0;
      if (m_push) begin
        mq.push_back('{rd: hold_rd, data: hold_dat});
        hold_v = 0;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
